aes_decrypt_stream_ctrl: RTL and testbench

//  Streaming controller for the AES decryption path: buffers ciphertext blocks from the UART

---
 rtl/aes_decrypt_stream_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_aes_decrypt_stream_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_stream_ctrl.sv
// Streaming controller for the AES decryption path: buffers ciphertext in a
// FIFO, feeds one block at a time to the inverse-cipher core, applies optional
// CBC chaining and returns plaintext on a valid/ready output.
module aes_decrypt_stream_ctrl #(
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CORE_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] key_in,
  input  logic              key_load,
  input  logic [DATA_W-1:0] iv_in,
  input  logic              iv_load,
  input  logic              cbc_en,
  output logic [DATA_W-1:0] core_key,
  output logic [DATA_W-1:0] core_data,
  output logic              core_start,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              key_valid,
  output logic              err_timeout,
  output logic [15:0]       blk_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(CORE_TIMEOUT) + 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(CORE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_OUTPUT
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              push, pop;

  logic [DATA_W-1:0] key_reg, key_shadow, iv_shadow, chain;
  logic              key_pend, iv_pend, cbc_q;
  logic [TW-1:0]     timer;
  logic              key_valid_eff, timeout_hit;

  assign in_ready      = (count != FULL_CNT);
  assign push          = in_valid & in_ready;
  assign core_key      = key_reg;
  // A key loaded (or pending) this very IDLE cycle already counts for the pop decision.
  assign key_valid_eff = key_valid | key_load | key_pend;
  assign timeout_hit   = (timer == TMO_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode, start pulse and FIFO pop
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    core_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (key_valid_eff && (count != '0) && !out_valid) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        core_start = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (core_done)        state_nxt = S_OUTPUT;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_OUTPUT: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage (no reset needed; pointers define validity)
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Key and IV/chain registers: loads apply in IDLE, otherwise shadowed until next IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      key_reg    <= '0;
      key_shadow <= '0;
      key_pend   <= 1'b0;
      key_valid  <= 1'b0;
      iv_shadow  <= '0;
      iv_pend    <= 1'b0;
      chain      <= '0;
    end else if (state == S_IDLE) begin
      // A fresh load in this cycle supersedes an older pending shadow value.
      if (key_load) begin
        key_reg   <= key_in;
        key_valid <= 1'b1;
      end else if (key_pend) begin
        key_reg   <= key_shadow;
        key_valid <= 1'b1;
      end
      key_pend <= 1'b0;
      if (iv_load)      chain <= iv_in;
      else if (iv_pend) chain <= iv_shadow;
      iv_pend <= 1'b0;
    end else begin
      if (key_load) begin
        key_shadow <= key_in;
        key_pend   <= 1'b1;
      end
      if (iv_load) begin
        iv_shadow <= iv_in;
        iv_pend   <= 1'b1;
      end
      if ((state == S_WAIT) && core_done && cbc_q) chain <= core_data;
    end
  end

  // Block datapath: issue, watchdog, output hold and delivery count
  always_ff @(posedge clk) begin
    if (rst) begin
      core_data   <= '0;
      cbc_q       <= 1'b0;
      timer       <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      blk_count   <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (pop) begin
        core_data <= fifo_mem[rd_ptr];
        cbc_q     <= cbc_en;
      end
      case (state)
        S_START: timer <= '0;
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (core_done) begin
            out_data  <= core_result ^ (cbc_q ? chain : '0);
            out_valid <= 1'b1;
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            blk_count <= blk_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_stream_ctrl.sv
// Directed bench for aes_decrypt_stream_ctrl with a behavioural core model
// that knows the FIPS-197 / SP800-38A vectors and otherwise returns data^key.
module tb_aes_decrypt_stream_ctrl;

  localparam int unsigned W   = 128;
  localparam int unsigned TMO = 16;
  localparam int unsigned LAT = 3;

  localparam logic [W-1:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [W-1:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [W-1:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;

  localparam logic [W-1:0] CBC_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [W-1:0] CBC_IV = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [W-1:0] CBC_C [4] = '{
    128'h7649abac8119b246cee98e9b12e9197d,
    128'h5086cb9b507219ee95db113a917678b2,
    128'h73bed6b8e3c1743b7116e69e22229516,
    128'h3ff1caa1681fac09120eca307586e1a7
  };
  localparam logic [W-1:0] CBC_P [4] = '{
    128'h6bc1bee22e409f96e93d7e117393172a,
    128'hae2d8a571e03ac9c9eb76fac45af8e51,
    128'h30c81c46a35ce411e5fbc1191a0a52ef,
    128'hf69f2445df4f9b17ad2b417be66c3710
  };

  localparam logic [W-1:0] K2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [W-1:0] K3 = 128'hcafebabedeadbeef0123456789abcdef;
  localparam logic [W-1:0] D1 = 128'h11111111222222223333333344444444;
  localparam logic [W-1:0] D2 = 128'h55555555666666667777777788888888;
  localparam logic [W-1:0] D3 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [W-1:0] D4 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [W-1:0] DX = 128'ha5a5a5a55a5a5a5aa5a5a5a55a5a5a5a;
  localparam logic [W-1:0] DY = 128'h13579bdf2468ace013579bdf2468ace0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] key_in = '0;
  logic         key_load = 1'b0;
  logic [W-1:0] iv_in = '0;
  logic         iv_load = 1'b0;
  logic         cbc_en = 1'b0;
  logic [W-1:0] core_key, core_data;
  logic         core_start;
  logic         core_done = 1'b0;
  logic [W-1:0] core_result = '0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         key_valid, err_timeout;
  logic [15:0]  blk_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [W-1:0] out_q [$];
  int unsigned  start_cnt = 0;

  logic         core_hang = 1'b0;
  logic         busy = 1'b0;
  int unsigned  lat_cnt = 0;

  aes_decrypt_stream_ctrl #(
    .DATA_W      (W),
    .FIFO_DEPTH  (4),
    .CORE_TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .key_in     (key_in),
    .key_load   (key_load),
    .iv_in      (iv_in),
    .iv_load    (iv_load),
    .cbc_en     (cbc_en),
    .core_key   (core_key),
    .core_data  (core_data),
    .core_start (core_start),
    .core_done  (core_done),
    .core_result(core_result),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .key_valid  (key_valid),
    .err_timeout(err_timeout),
    .blk_count  (blk_count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] core_model(input logic [W-1:0] d, input logic [W-1:0] k);
    logic [W-1:0] r;
    r = d ^ k;
    if (k == FIPS_K && d == FIPS_C) r = FIPS_P;
    if (k == CBC_K) begin
      for (int i = 0; i < 4; i++)
        if (d == CBC_C[i]) r = CBC_P[i] ^ ((i == 0) ? CBC_IV : CBC_C[(i == 0) ? 0 : i-1]);
    end
    return r;
  endfunction

  // Core model: done LAT cycles after start, result from the operands present at done
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (rst) begin
      busy <= 1'b0;
    end else if (core_start && !core_hang) begin
      busy    <= 1'b1;
      lat_cnt <= LAT;
    end else if (busy) begin
      if (lat_cnt == 1) begin
        core_done   <= 1'b1;
        core_result <= core_model(core_data, core_key);
        busy        <= 1'b0;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  // Output and start monitors
  always @(negedge clk) begin
    if (out_valid && out_ready) out_q.push_back(out_data);
    if (core_start) start_cnt <= start_cnt + 1;
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_blk(input logic [W-1:0] d);
    int unsigned n = 0;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] k, input logic kl, input logic [W-1:0] iv, input logic il);
    @(negedge clk);
    key_in   = k;
    key_load = kl;
    iv_in    = iv;
    iv_load  = il;
    @(negedge clk);
    key_load = 1'b0;
    iv_load  = 1'b0;
  endtask

  task automatic wait_out(input int unsigned n, input string tag);
    int unsigned c = 0;
    while (out_q.size() < n && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk(tag, out_q.size(), n);
  endtask

  task automatic wait_start(input string tag);
    int unsigned c = 0;
    while (!core_start && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk(tag, core_start, 1);
  endtask

  initial begin
    int unsigned qb;
    int unsigned sc;
    int unsigned unstable;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_blk", blk_count, 0);
    chk("rst_start", core_start, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_core_data", core_data, 0);
    chk("rst_out_data", out_data, 0);

    // ECB FIPS-197
    load(FIPS_K, 1'b1, '0, 1'b0);
    chk("ecb_key_valid", key_valid, 1);
    cbc_en = 1'b0;
    push_blk(FIPS_C);
    wait_out(1, "ecb_cnt");
    chk("ecb_out", out_q[0], FIPS_P);
    repeat (2) @(negedge clk);
    chk("ecb_blk", blk_count, 1);

    // Reset between tests clears the key so the FIFO can be filled with nothing issued
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_q.delete();
    sc = start_cnt;

    // CBC SP800-38A: fill FIFO, then load key+IV
    cbc_en = 1'b1;
    for (int i = 0; i < 4; i++) push_blk(CBC_C[i]);
    chk("cbc_full", in_ready, 0);
    chk("cbc_nostart", start_cnt, sc);
    load(CBC_K, 1'b1, CBC_IV, 1'b1);
    wait_out(4, "cbc_cnt");
    for (int i = 0; i < 4; i++) chk($sformatf("cbc_out%0d", i), out_q[i], CBC_P[i]);
    repeat (2) @(negedge clk);
    chk("cbc_blk", blk_count, 4);

    // Backpressure: hold first output for 20 cycles
    cbc_en    = 1'b0;
    out_ready = 1'b0;
    load(K2, 1'b1, '0, 1'b0);
    push_blk(D1);
    push_blk(D2);
    begin
      int unsigned c = 0;
      while (!out_valid && c < 100) begin
        @(negedge clk);
        c++;
      end
    end
    sc = start_cnt;
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_data !== (D1 ^ K2) || !out_valid) unstable++;
    end
    chk("bp_stable", unstable, 0);
    chk("bp_hold", out_data, D1 ^ K2);
    chk("bp_nostart", start_cnt, sc);
    qb = out_q.size();
    @(negedge clk);
    out_ready = 1'b1;
    wait_out(qb + 2, "bp_cnt");
    chk("bp_out0", out_q[qb], D1 ^ K2);
    chk("bp_out1", out_q[qb+1], D2 ^ K2);

    // Key reload while a block is in flight
    qb = out_q.size();
    push_blk(D3);
    wait_start("key_start");
    load(K3, 1'b1, '0, 1'b0);
    push_blk(D4);
    wait_out(qb + 2, "key_cnt");
    chk("key_old", out_q[qb], D3 ^ K2);
    chk("key_new", out_q[qb+1], D4 ^ K3);

    // Watchdog: core never answers; chain (last CBC ciphertext) must survive
    repeat (2) @(negedge clk);
    cbc_en    = 1'b1;
    core_hang = 1'b1;
    qb = out_q.size();
    push_blk(DX);
    wait_start("tmo_start");
    repeat (TMO) @(negedge clk);
    chk("tmo_early", err_timeout, 0);
    @(negedge clk);
    chk("tmo_fire", err_timeout, 1);
    core_hang = 1'b0;
    push_blk(DY);
    wait_out(qb + 1, "tmo_cnt");
    chk("tmo_next", out_q[qb], DY ^ K3 ^ CBC_C[3]);

    // Reset while waiting on the core with three blocks queued
    repeat (2) @(negedge clk);
    cbc_en    = 1'b0;
    core_hang = 1'b1;
    qb = out_q.size();
    for (int i = 0; i < 4; i++) push_blk(D1 + W'(i));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rmid_in_ready", in_ready, 1);
    chk("rmid_out_valid", out_valid, 0);
    chk("rmid_err", err_timeout, 0);
    sc = start_cnt;
    core_hang = 1'b0;
    repeat (10) @(negedge clk);
    chk("rmid_noout", out_q.size(), qb);
    chk("rmid_nostart", start_cnt, sc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
